// File: rtl/pipe_reg_chain_if.sv
// Bundle of control, input and output signals for one pipeline register chain.
// The master drives stall/flush and the incoming word; the slave is the chain.
interface pipe_reg_chain_if #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 1
);
   localparam int unsigned OccW = $clog2(DEPTH + 1);

   logic             stall;
   logic             flush;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic [OccW-1:0]  occupancy;

   modport master (
      output stall,
      output flush,
      output in_valid,
      output in_data,
      input  out_valid,
      input  out_data,
      input  occupancy
   );

   modport slave (
      input  stall,
      input  flush,
      input  in_valid,
      input  in_data,
      output out_valid,
      output out_data,
      output occupancy
   );
endinterface

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage pipeline register chain with per-stage valid bits, global stall,
// flush-to-bubble and a registered count of valid stages.
module pipe_reg_chain #(
   parameter int unsigned      WIDTH  = 64,
   parameter int unsigned      DEPTH  = 1,
   parameter logic [WIDTH-1:0] BUBBLE = '0
) (
   input logic             clk,
   input logic             reset,
   pipe_reg_chain_if.slave bus
);
   localparam int unsigned OccW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] data_q [DEPTH];
   logic [WIDTH-1:0] data_d [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] valid_d;
   logic [OccW-1:0]  occ_q;
   logic [OccW-1:0]  occ_d;

   // Next state: reset beats flush, flush beats stall, otherwise shift by one.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      occ_d   = occ_q;
      if (reset) begin
         for (int unsigned k = 0; k < DEPTH; k++) begin
            data_d[k] = '0;
         end
         valid_d = '0;
         occ_d   = '0;
      end else if (bus.flush) begin
         for (int unsigned k = 0; k < DEPTH; k++) begin
            data_d[k] = BUBBLE;
         end
         valid_d = '0;
         occ_d   = '0;
      end else if (!bus.stall) begin
         // Data moves even when invalid; the valid bit alone qualifies it.
         data_d[0]  = bus.in_data;
         valid_d[0] = bus.in_valid;
         for (int unsigned k = 1; k < DEPTH; k++) begin
            data_d[k]  = data_q[k-1];
            valid_d[k] = valid_q[k-1];
         end
         // Enter and leave in the same cycle cancel, so occ tracks popcount(valid).
         occ_d = occ_q + OccW'(bus.in_valid) - OccW'(valid_q[DEPTH-1]);
      end
   end

   // State register for all stages and the occupancy counter.
   always_ff @(posedge clk) begin
      data_q  <= data_d;
      valid_q <= valid_d;
      occ_q   <= occ_d;
   end

   assign bus.out_valid = valid_q[DEPTH-1];
   assign bus.out_data  = data_q[DEPTH-1];
   assign bus.occupancy = occ_q;
endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain at DEPTH 3, 2 and 1 with hand-computed expectations.
module tb_pipe_reg_chain;
   logic clk;
   logic rst3;
   logic rst12;
   int   checks;
   int   errors;

   pipe_reg_chain_if #(.WIDTH(64), .DEPTH(3)) b3 ();
   pipe_reg_chain_if #(.WIDTH(64), .DEPTH(2)) b2 ();
   pipe_reg_chain_if #(.WIDTH(8),  .DEPTH(1)) b1 ();

   pipe_reg_chain #(.WIDTH(64), .DEPTH(3), .BUBBLE(64'hDEAD)) dut3 (
      .clk   (clk),
      .reset (rst3),
      .bus   (b3)
   );

   pipe_reg_chain #(.WIDTH(64), .DEPTH(2), .BUBBLE(64'h0)) dut2 (
      .clk   (clk),
      .reset (rst12),
      .bus   (b2)
   );

   pipe_reg_chain #(.WIDTH(8), .DEPTH(1), .BUBBLE(8'h3C)) dut1 (
      .clk   (clk),
      .reset (rst12),
      .bus   (b1)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock edge, then the occupancy-equals-popcount invariant on every chain.
   task automatic tick();
      @(posedge clk);
      #1;
      chk("inv3", 64'($countones(dut3.valid_q)), 64'(b3.occupancy));
      chk("inv2", 64'($countones(dut2.valid_q)), 64'(b2.occupancy));
      chk("inv1", 64'(b1.out_valid), 64'(b1.occupancy));
   endtask

   task automatic exp3(input string tag, input logic v, input logic [63:0] d,
                       input logic [1:0] o);
      chk({tag, "_v3"}, 64'(b3.out_valid), 64'(v));
      chk({tag, "_d3"}, b3.out_data, d);
      chk({tag, "_o3"}, 64'(b3.occupancy), 64'(o));
   endtask

   task automatic exp2(input string tag, input logic v, input logic [63:0] d,
                       input logic [1:0] o);
      chk({tag, "_v2"}, 64'(b2.out_valid), 64'(v));
      chk({tag, "_d2"}, b2.out_data, d);
      chk({tag, "_o2"}, 64'(b2.occupancy), 64'(o));
   endtask

   task automatic exp1(input string tag, input logic v, input logic [7:0] d, input logic o);
      chk({tag, "_v1"}, 64'(b1.out_valid), 64'(v));
      chk({tag, "_d1"}, 64'(b1.out_data), 64'(d));
      chk({tag, "_o1"}, 64'(b1.occupancy), 64'(o));
   endtask

   task automatic drv3(input logic st, input logic fl, input logic v, input logic [63:0] d);
      b3.stall    = st;
      b3.flush    = fl;
      b3.in_valid = v;
      b3.in_data  = d;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst3   = 1'b1;
      rst12  = 1'b1;
      drv3(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
      b2.stall = 1'b0; b2.flush = 1'b0; b2.in_valid = 1'b1; b2.in_data = '1;
      b1.stall = 1'b0; b1.flush = 1'b0; b1.in_valid = 1'b1; b1.in_data = '1;

      // Reset held for two cycles with all-ones valid input.
      tick();
      exp3("rst_a", 1'b0, 64'h0, 2'd0);
      exp2("rst_a", 1'b0, 64'h0, 2'd0);
      exp1("rst_a", 1'b0, 8'h00, 1'b0);
      tick();
      exp3("rst_b", 1'b0, 64'h0, 2'd0);

      rst3 = 1'b0;
      rst12 = 1'b0;
      drv3(1'b0, 1'b0, 1'b0, 64'h0);
      b2.in_valid = 1'b0; b2.in_data = '0;
      b1.in_valid = 1'b0; b1.in_data = '0;
      for (int i = 0; i < 3; i++) begin
         tick();
         exp3("nostale", 1'b0, 64'h0, 2'd0);
      end

      // Latency and ordering through three stages.
      drv3(1'b0, 1'b0, 1'b1, 64'd1); tick(); exp3("lat1", 1'b0, 64'd0, 2'd1);
      drv3(1'b0, 1'b0, 1'b1, 64'd2); tick(); exp3("lat2", 1'b0, 64'd0, 2'd2);
      drv3(1'b0, 1'b0, 1'b1, 64'd3); tick(); exp3("lat3", 1'b1, 64'd1, 2'd3);
      drv3(1'b0, 1'b0, 1'b1, 64'd4); tick(); exp3("lat4", 1'b1, 64'd2, 2'd3);
      drv3(1'b0, 1'b0, 1'b0, 64'd0); tick(); exp3("lat5", 1'b1, 64'd3, 2'd2);
      tick(); exp3("lat6", 1'b1, 64'd4, 2'd1);
      tick(); exp3("lat7", 1'b0, 64'd0, 2'd0);

      // Stall with 10/20/30 resident; 99 must never enter.
      drv3(1'b0, 1'b0, 1'b1, 64'd30); tick();
      drv3(1'b0, 1'b0, 1'b1, 64'd20); tick();
      drv3(1'b0, 1'b0, 1'b1, 64'd10); tick(); exp3("full", 1'b1, 64'd30, 2'd3);
      drv3(1'b1, 1'b0, 1'b1, 64'd99);
      for (int i = 0; i < 4; i++) begin
         tick();
         exp3("stall", 1'b1, 64'd30, 2'd3);
      end
      drv3(1'b0, 1'b0, 1'b0, 64'd0);
      tick(); exp3("resume1", 1'b1, 64'd20, 2'd2);
      tick(); exp3("resume2", 1'b1, 64'd10, 2'd1);
      tick(); exp3("resume3", 1'b0, 64'd0, 2'd0);

      // Flush and stall together on a full chain; every stage becomes DEAD.
      drv3(1'b0, 1'b0, 1'b1, 64'd7); tick();
      drv3(1'b0, 1'b0, 1'b1, 64'd8); tick();
      drv3(1'b0, 1'b0, 1'b1, 64'd9); tick(); exp3("pref", 1'b1, 64'd7, 2'd3);
      drv3(1'b1, 1'b1, 1'b1, 64'd55); tick(); exp3("flush", 1'b0, 64'hDEAD, 2'd0);
      drv3(1'b0, 1'b0, 1'b0, 64'd0);
      tick(); exp3("bub1", 1'b0, 64'hDEAD, 2'd0);
      tick(); exp3("bub2", 1'b0, 64'hDEAD, 2'd0);
      tick(); exp3("bub3", 1'b0, 64'h0, 2'd0);

      // Reset mid-stream with two valid entries and a concurrent valid input.
      drv3(1'b0, 1'b0, 1'b1, 64'hA1); tick();
      drv3(1'b0, 1'b0, 1'b1, 64'hA2); tick(); exp3("mid_pre", 1'b0, 64'h0, 2'd2);
      rst3 = 1'b1;
      drv3(1'b0, 1'b0, 1'b1, 64'hA3); tick(); exp3("mid_rst", 1'b0, 64'h0, 2'd0);
      rst3 = 1'b0;
      drv3(1'b0, 1'b0, 1'b1, 64'hB1); tick(); exp3("mid_n1", 1'b0, 64'h0, 2'd1);
      drv3(1'b0, 1'b0, 1'b0, 64'h0);
      tick(); exp3("mid_n2", 1'b0, 64'h0, 2'd1);
      tick(); exp3("mid_n3", 1'b1, 64'hB1, 2'd1);
      tick(); exp3("mid_n4", 1'b0, 64'h0, 2'd0);

      // DEPTH 2: bubbles and simultaneous enter/leave.
      b2.in_valid = 1'b1; b2.in_data = 64'd5; tick(); exp2("b1", 1'b0, 64'd0, 2'd1);
      b2.in_valid = 1'b0; b2.in_data = 64'd6; tick(); exp2("b2", 1'b1, 64'd5, 2'd1);
      b2.in_valid = 1'b1; b2.in_data = 64'd7; tick(); exp2("b3", 1'b0, 64'd6, 2'd1);
      b2.in_valid = 1'b1; b2.in_data = 64'd8; tick(); exp2("b4", 1'b1, 64'd7, 2'd2);
      b2.in_valid = 1'b0; b2.in_data = 64'd0; tick(); exp2("b5", 1'b1, 64'd8, 2'd1);
      tick(); exp2("b6", 1'b0, 64'd0, 2'd0);

      // DEPTH 1: enabled register with clear.
      b1.in_valid = 1'b1; b1.in_data = 8'hA5; tick(); exp1("d1_load", 1'b1, 8'hA5, 1'b1);
      b1.stall = 1'b1; b1.in_data = 8'h11;
      tick(); exp1("d1_stall", 1'b1, 8'hA5, 1'b1);
      b1.stall = 1'b0; b1.in_valid = 1'b0; b1.in_data = 8'h22;
      tick(); exp1("d1_inv", 1'b0, 8'h22, 1'b0);
      b1.flush = 1'b1; b1.in_valid = 1'b1; b1.in_data = 8'h33;
      tick(); exp1("d1_flush", 1'b0, 8'h3C, 1'b0);
      b1.flush = 1'b0; b1.in_data = 8'h44;
      tick(); exp1("d1_44", 1'b1, 8'h44, 1'b1);
      b1.in_data = 8'h55;
      tick(); exp1("d1_55", 1'b1, 8'h55, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
